// File: rtl/hyper_mvblck_if.sv
// Block-move bus: command, status, source-pop and sink-write signals.
// The block itself attaches through the slave modport.
interface hyper_mvblck_if;
  logic        BLCK_ISSUE;
  logic [8:0]  BLCK_START;
  logic [5:0]  BLCK_COUNT_REQ;
  logic [1:0]  BLCK_SECTION;
  logic        SRC_VALID;
  logic [15:0] SRC_DATA;
  logic        SRC_LAST;
  logic        SRC_POP;
  logic        DEVERR;
  logic        DST_READY;
  logic        DST_WE;
  logic [8:0]  DST_ADDR;
  logic [15:0] DST_DATA;
  logic [5:0]  BLCK_COUNT_SENT;
  logic        BLCK_WORKING;
  logic        BLCK_IRQ;
  logic        BLCK_ABRUPT_STOP;
  logic        BLCK_FRDRAM_DEVERR;
  logic [1:0]  SECTION_OUT;

  modport master (
    output BLCK_ISSUE, BLCK_START, BLCK_COUNT_REQ, BLCK_SECTION,
    output SRC_VALID, SRC_DATA, SRC_LAST, DEVERR, DST_READY,
    input  SRC_POP, DST_WE, DST_ADDR, DST_DATA,
    input  BLCK_COUNT_SENT, BLCK_WORKING, BLCK_IRQ,
    input  BLCK_ABRUPT_STOP, BLCK_FRDRAM_DEVERR, SECTION_OUT
  );

  modport slave (
    input  BLCK_ISSUE, BLCK_START, BLCK_COUNT_REQ, BLCK_SECTION,
    input  SRC_VALID, SRC_DATA, SRC_LAST, DEVERR, DST_READY,
    output SRC_POP, DST_WE, DST_ADDR, DST_DATA,
    output BLCK_COUNT_SENT, BLCK_WORKING, BLCK_IRQ,
    output BLCK_ABRUPT_STOP, BLCK_FRDRAM_DEVERR, SECTION_OUT
  );
endinterface

// File: rtl/hyper_mvblck.sv
// Toggle-triggered block mover: copies source words into a 9-bit
// wrapping destination window, with completion and abort status.
module hyper_mvblck (
  input  logic          CLK,
  input  logic          RST,
  hyper_mvblck_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_issue_seen;
  logic [8:0]  r_start;
  logic [5:0]  r_count;
  logic [1:0]  r_section;
  logic [5:0]  r_sent;
  logic [5:0]  r_idle_cnt;
  logic        r_irq;
  logic        r_abrupt;
  logic        r_deverr;
  logic        r_working;

  logic        w_seen_nxt;
  logic [8:0]  w_start_nxt;
  logic [5:0]  w_count_nxt;
  logic [1:0]  w_sec_nxt;
  logic [5:0]  w_sent_nxt;
  logic [5:0]  w_idle_nxt;
  logic        w_irq_nxt;
  logic        w_abrupt_nxt;
  logic        w_dev_nxt;
  logic        w_working_nxt;

  logic        w_xfer;
  logic        w_avail;
  logic        w_done;
  logic [5:0]  w_sent_inc;

  assign w_avail    = bus.SRC_VALID & bus.DST_READY;
  assign w_done     = (r_sent == r_count);
  assign w_sent_inc = r_sent + 6'd1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_seen_nxt    = r_issue_seen;
    w_start_nxt   = r_start;
    w_count_nxt   = r_count;
    w_sec_nxt     = r_section;
    w_sent_nxt    = r_sent;
    w_idle_nxt    = r_idle_cnt;
    w_irq_nxt     = r_irq;
    w_abrupt_nxt  = r_abrupt;
    w_dev_nxt     = r_deverr;
    w_working_nxt = r_working;
    w_xfer        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.BLCK_ISSUE != r_issue_seen) begin
          w_seen_nxt    = bus.BLCK_ISSUE;
          w_start_nxt   = bus.BLCK_START;
          w_count_nxt   = bus.BLCK_COUNT_REQ;
          w_sec_nxt     = bus.BLCK_SECTION;
          w_sent_nxt    = '0;
          w_idle_nxt    = '0;
          w_irq_nxt     = 1'b0;
          w_abrupt_nxt  = 1'b0;
          w_dev_nxt     = 1'b0;
          w_working_nxt = 1'b1;
          w_state_nxt   = S_MOVE;
        end
      end
      S_MOVE: begin
        // device error wins over completion, transfer and timeout
        if (bus.DEVERR) begin
          w_dev_nxt    = 1'b1;
          w_abrupt_nxt = 1'b1;
          w_state_nxt  = S_DONE;
        end else if (w_done) begin
          w_state_nxt = S_DONE;
        end else if (w_avail) begin
          w_xfer     = 1'b1;
          w_sent_nxt = w_sent_inc;
          w_idle_nxt = '0;
          if (bus.SRC_LAST) begin
            w_irq_nxt = 1'b1;
            if (w_sent_inc != r_count) begin
              w_abrupt_nxt = 1'b1;
              w_state_nxt  = S_DONE;
            end
          end
        end else begin
          w_idle_nxt = r_idle_cnt + 6'd1;
          if (r_idle_cnt == 6'd62) begin
            w_abrupt_nxt = 1'b1;
            w_state_nxt  = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_working_nxt = 1'b0;
        w_state_nxt   = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_issue_seen <= 1'b0;
      r_start      <= '0;
      r_count      <= '0;
      r_section    <= '0;
      r_sent       <= '0;
      r_idle_cnt   <= '0;
      r_irq        <= 1'b0;
      r_abrupt     <= 1'b0;
      r_deverr     <= 1'b0;
      r_working    <= 1'b0;
    end else begin
      r_issue_seen <= w_seen_nxt;
      r_start      <= w_start_nxt;
      r_count      <= w_count_nxt;
      r_section    <= w_sec_nxt;
      r_sent       <= w_sent_nxt;
      r_idle_cnt   <= w_idle_nxt;
      r_irq        <= w_irq_nxt;
      r_abrupt     <= w_abrupt_nxt;
      r_deverr     <= w_dev_nxt;
      r_working    <= w_working_nxt;
    end
  end

  // write port is zero whenever no word moves
  assign bus.SRC_POP  = w_xfer;
  assign bus.DST_WE   = w_xfer;
  assign bus.DST_ADDR = w_xfer ? (r_start + {3'b000, r_sent}) : '0;
  assign bus.DST_DATA = w_xfer ? bus.SRC_DATA : '0;

  assign bus.BLCK_COUNT_SENT    = r_sent;
  assign bus.BLCK_WORKING       = r_working;
  assign bus.BLCK_IRQ           = r_irq;
  assign bus.BLCK_ABRUPT_STOP   = r_abrupt;
  assign bus.BLCK_FRDRAM_DEVERR = r_deverr;
  assign bus.SECTION_OUT        = r_section;

endmodule

// File: tb/tb_hyper_mvblck.sv
// Scoreboard bench for hyper_mvblck: randomized and directed moves
// against a word-list reference model.
module tb_hyper_mvblck;
  logic clk = 1'b0;
  logic rst = 1'b1;

  hyper_mvblck_if bus();

  hyper_mvblck dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  a;
    logic [15:0] d;
  } wr_t;

  typedef struct {
    int sent;
    int irq;
    int ab;
    int dev;
    int sec;
    int dur;
    int gap;
  } st_t;

  wr_t         wq[$];
  st_t         sq[$];
  logic [15:0] words[$];
  bit          lasts[$];

  int   vectors = 0;
  int   misses  = 0;
  int   hi_cnt  = 0;
  int   lo_cnt  = 0;
  int   gap_seen = 0;
  logic prev_w  = 1'b0;
  int   idx     = 0;

  task automatic chk(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      misses++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_pop"},   bus.SRC_POP, 0);
    chk({tag, "_we"},    bus.DST_WE, 0);
    chk({tag, "_addr"},  bus.DST_ADDR, 0);
    chk({tag, "_data"},  bus.DST_DATA, 0);
    chk({tag, "_sent"},  bus.BLCK_COUNT_SENT, 0);
    chk({tag, "_work"},  bus.BLCK_WORKING, 0);
    chk({tag, "_irq"},   bus.BLCK_IRQ, 0);
    chk({tag, "_abort"}, bus.BLCK_ABRUPT_STOP, 0);
    chk({tag, "_dev"},   bus.BLCK_FRDRAM_DEVERR, 0);
    chk({tag, "_sec"},   bus.SECTION_OUT, 0);
  endtask

  task automatic gen_words(int n, int lastpos);
    words.delete();
    lasts.delete();
    for (int i = 0; i < n; i++) begin
      words.push_back(16'($urandom));
      lasts.push_back(i == lastpos);
    end
  endtask

  // Reference: walk the word list, stopping at count, error, starvation or last.
  task automatic push_expect(int start, int cnt, int sec, int base,
                             int dev_at, int vlim, int dur, int gap);
    st_t s;
    wr_t w;
    int  k;
    k = 0;
    s = '{0, 0, 0, 0, sec, dur, gap};
    for (int i = 0; i < cnt; i++) begin
      if (i == dev_at) begin
        s.dev = 1;
        s.ab  = 1;
        break;
      end
      if (i == vlim) begin
        s.ab = 1;
        break;
      end
      w.a = 9'((start + i) % 512);
      w.d = words[base + i];
      wq.push_back(w);
      k++;
      if (lasts[base + i]) begin
        s.irq = 1;
        s.ab  = (i + 1 != cnt) ? 1 : 0;
        break;
      end
    end
    s.sent = k;
    sq.push_back(s);
  endtask

  task automatic run_move(int start, int cnt, int sec, int dev_at, int vlim,
                          int vprob, int rprob, int tog, int retog, int rst_at);
    bit w;
    bit pw;
    bit vnow;
    int falls;
    int need;
    int cyc;
    falls = 0;
    cyc   = 0;
    pw    = 1'b0;
    idx   = 0;
    need  = (retog >= 0) ? 2 : 1;
    forever begin
      @(negedge clk);
      if (cyc == rst_at) begin
        wq.delete();
        sq.delete();
        rst = 1'b1;
        #1;
        check_zero("midrst");
        bus.BLCK_ISSUE = 1'b1;
        break;
      end
      if (cyc == 0) begin
        bus.BLCK_START     = 9'(start);
        bus.BLCK_COUNT_REQ = 6'(cnt);
        bus.BLCK_SECTION   = 2'(sec);
        if (tog == 1) bus.BLCK_ISSUE = ~bus.BLCK_ISSUE;
        else if (tog == 2) rst = 1'b0;
      end
      if (cyc == 2 && retog >= 0) begin
        bus.BLCK_START   = 9'(retog);
        bus.BLCK_SECTION = ~bus.BLCK_SECTION;
        bus.BLCK_ISSUE   = ~bus.BLCK_ISSUE;
      end
      vnow = (idx < words.size()) && (idx < vlim) &&
             ($urandom_range(0, 99) < vprob);
      bus.SRC_VALID = vnow;
      bus.SRC_DATA  = vnow ? words[idx] : 16'h0;
      bus.SRC_LAST  = vnow && lasts[idx];
      bus.DST_READY = ($urandom_range(0, 99) < rprob);
      bus.DEVERR    = vnow && (idx == dev_at);
      #1;
      if (bus.SRC_POP) idx++;
      w = bus.BLCK_WORKING;
      if (pw && !w) falls++;
      pw = w;
      cyc++;
      if (falls == need) break;
      if (cyc > 400) begin
        vectors++;
        misses++;
        $display("FAIL move_bound: got %0d falls expected %0d", falls, need);
        break;
      end
    end
    bus.SRC_VALID = 1'b0;
    bus.SRC_LAST  = 1'b0;
    bus.DEVERR    = 1'b0;
    bus.DST_READY = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: checks every write and every completion independently.
  initial begin
    wr_t ew;
    st_t es;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_w = 1'b0;
        hi_cnt = 0;
        lo_cnt = 0;
      end else begin
        if (bus.DST_WE) begin
          if (wq.size() == 0) begin
            vectors++;
            misses++;
            $display("FAIL unexpected_write: got addr %0d expected none",
                     bus.DST_ADDR);
          end else begin
            ew = wq.pop_front();
            chk("wr_addr", bus.DST_ADDR, ew.a);
            chk("wr_data", bus.DST_DATA, ew.d);
          end
        end
        if (!bus.BLCK_WORKING && prev_w) begin
          if (sq.size() == 0) begin
            vectors++;
            misses++;
            $display("FAIL unexpected_done: got sent %0d expected none",
                     bus.BLCK_COUNT_SENT);
          end else begin
            es = sq.pop_front();
            chk("sent",  bus.BLCK_COUNT_SENT, es.sent);
            chk("irq",   bus.BLCK_IRQ, es.irq);
            chk("abort", bus.BLCK_ABRUPT_STOP, es.ab);
            chk("dev",   bus.BLCK_FRDRAM_DEVERR, es.dev);
            chk("sec",   bus.SECTION_OUT, es.sec);
            if (es.dur >= 0) chk("work_cycles", hi_cnt, es.dur);
            if (es.gap >= 0) chk("idle_gap", gap_seen, es.gap);
          end
          lo_cnt = 0;
        end
        if (bus.BLCK_WORKING && !prev_w) begin
          gap_seen = lo_cnt;
          hi_cnt   = 0;
        end
        if (bus.BLCK_WORKING) hi_cnt++;
        else lo_cnt++;
        prev_w = bus.BLCK_WORKING;
      end
    end
  end

  initial begin
    int c;
    int lp;
    int dv;
    int st;
    int sc;
    bus.BLCK_ISSUE     = 1'b0;
    bus.BLCK_START     = '0;
    bus.BLCK_COUNT_REQ = '0;
    bus.BLCK_SECTION   = '0;
    bus.SRC_VALID      = 1'b0;
    bus.SRC_DATA       = '0;
    bus.SRC_LAST       = 1'b0;
    bus.DEVERR         = 1'b0;
    bus.DST_READY      = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_zero("rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_zero("idle");

    gen_words(34, -1);
    push_expect(9'h1F0, 32, 1, 0, -1, 1000, 34, -1);
    run_move(9'h1F0, 32, 1, -1, 1000, 100, 100, 1, -1, -1);

    gen_words(10, 4);
    push_expect(3, 8, 2, 0, -1, 1000, 6, -1);
    run_move(3, 8, 2, -1, 1000, 100, 100, 1, -1, -1);

    gen_words(10, -1);
    push_expect(100, 8, 3, 0, -1, 3, 67, -1);
    run_move(100, 8, 3, -1, 3, 100, 100, 1, -1, -1);

    gen_words(10, -1);
    push_expect(200, 8, 0, 0, 3, 1000, 5, -1);
    run_move(200, 8, 0, 3, 1000, 100, 100, 1, -1, -1);

    gen_words(2, -1);
    push_expect(50, 0, 1, 0, -1, 1000, 2, -1);
    run_move(50, 0, 1, -1, 1000, 100, 100, 1, -1, -1);

    gen_words(8, 5);
    push_expect(7, 6, 2, 0, -1, 1000, 8, -1);
    run_move(7, 6, 2, -1, 1000, 100, 100, 1, -1, -1);

    gen_words(10, -1);
    push_expect(300, 4, 1, 0, -1, 1000, 6, -1);
    push_expect(500, 4, 2, 4, -1, 1000, 6, 1);
    run_move(300, 4, 1, -1, 1000, 100, 100, 1, 500, -1);

    for (int t = 0; t < 20; t++) begin
      c  = $urandom_range(1, 20);
      lp = ($urandom_range(0, 1) == 1) ? $urandom_range(0, c + 1) : -1;
      dv = ($urandom_range(0, 4) == 0) ? $urandom_range(0, c - 1) : -1;
      st = $urandom_range(0, 511);
      sc = $urandom_range(0, 3);
      gen_words(c + 2, lp);
      push_expect(st, c, sc, 0, dv, 1000, -1, -1);
      run_move(st, c, sc, dv, 1000, 80, 70, 1, -1, -1);
    end

    gen_words(32, -1);
    push_expect(20, 30, 2, 0, -1, 1000, -1, -1);
    run_move(20, 30, 2, -1, 1000, 100, 50, 1, -1, 8);

    gen_words(7, -1);
    push_expect(40, 5, 3, 0, -1, 1000, 7, -1);
    run_move(40, 5, 3, -1, 1000, 100, 100, 2, -1, -1);

    gen_words(6, -1);
    push_expect(510, 4, 0, 0, -1, 1000, 6, -1);
    run_move(510, 4, 0, -1, 1000, 100, 100, 1, -1, -1);

    repeat (3) @(negedge clk);
    chk("wr_queue_left", wq.size(), 0);
    chk("st_queue_left", sq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end
endmodule

// File: doc/hyper_mvblck.md
HYPER_MVBLCK -- requirements
Module: hyper_mvblck

Interface
REQ-001 The block SHALL use one clock and one reset; reset is asynchronous and active-high.
REQ-002 CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 RST  input  1  asynchronous active-high reset.
REQ-004 BLCK_ISSUE  input  1  toggle request; any level change relative to the last accepted level is one new move request.
REQ-005 BLCK_START  input  9  first destination word address, sampled at acceptance.
REQ-006 BLCK_COUNT_REQ  input  6  words to move, sampled at acceptance.
REQ-007 BLCK_SECTION  input  2  section tag, sampled at acceptance and held on SECTION_OUT.
REQ-008 SRC_VALID  input  1  source word available; SRC_DATA  input  16; SRC_LAST  input  1 (end-of-packet marker on current word).
REQ-009 SRC_POP  output  1  source word consumed this cycle.
REQ-010 DEVERR  input  1  source device error.
REQ-011 DST_READY  input  1  sink accepts a word this cycle.
REQ-012 DST_WE  output  1; DST_ADDR  output  9; DST_DATA  output  16  destination write port.
REQ-013 BLCK_COUNT_SENT  output  6  words moved in the last/current move.
REQ-014 BLCK_WORKING  output  1  high from acceptance until move completes.
REQ-015 BLCK_IRQ, BLCK_ABRUPT_STOP, BLCK_FRDRAM_DEVERR  outputs  1 each  completion status, valid from WORKING falling edge until next acceptance.
REQ-016 SECTION_OUT  output  2  section of the current/last move.

Function
REQ-017 States SHALL be IDLE, MOVE, DONE; reset state IDLE.
REQ-018 IDLE: when BLCK_ISSUE != issue_seen, the block SHALL set issue_seen <= BLCK_ISSUE, latch START/COUNT_REQ/SECTION, clear COUNT_SENT and all status flags, set WORKING, go to MOVE.
REQ-019 A toggle arriving while not IDLE SHALL NOT be lost; it is accepted on the first IDLE cycle.
REQ-020 MOVE: a transfer occurs in a cycle iff SRC_VALID and DST_READY and sent != count; then SRC_POP=1, DST_WE=1, DST_DATA=SRC_DATA, DST_ADDR=(START+sent) mod 512 (9-bit wrap), sent increments; all combinational, zero latency.
REQ-021 MOVE exits to DONE on the cycle after sent reaches count (normal completion).
REQ-022 A transfer with SRC_LAST=1 SHALL set BLCK_IRQ; if that word is not the count-th word, also set BLCK_ABRUPT_STOP and exit to DONE after it.
REQ-023 DEVERR high in MOVE SHALL set BLCK_FRDRAM_DEVERR and BLCK_ABRUPT_STOP, suppress any transfer that cycle, and exit to DONE.
REQ-024 An idle counter SHALL count MOVE cycles without a transfer; reaching 63 SHALL set BLCK_ABRUPT_STOP and exit to DONE; any transfer clears it.
REQ-025 DEVERR has priority over timeout; a SRC_LAST transfer and completion in the same word SHALL give IRQ=1, ABRUPT_STOP=0.
REQ-026 COUNT_REQ=0 SHALL go MOVE->DONE with no transfer; WORKING high exactly 2 cycles.
REQ-027 DONE: WORKING <= 0, COUNT_SENT holds final value, return to IDLE next cycle.
REQ-028 COUNT_SENT SHALL track sent live during MOVE.

Reset
REQ-029 RST SHALL force, at any time including mid-move: state IDLE, WORKING=0, SRC_POP=0, DST_WE=0, COUNT_SENT=0, all status flags=0, SECTION_OUT=0, issue_seen=0, idle counter=0.
REQ-030 After reset release with BLCK_ISSUE=1, one move SHALL be accepted (issue_seen=0 mismatch).

Verification
REQ-031 START=0x1F0, COUNT=32, source always valid, sink ready -> 32 writes to addresses 0x1F0..0x1FF,0x000..0x00F, COUNT_SENT=32, WORKING high 34 cycles, no flags.
REQ-032 COUNT=8, SRC_LAST on word 5 -> 5 writes, COUNT_SENT=5, IRQ=1, ABRUPT_STOP=1.
REQ-033 COUNT=8, SRC_VALID dropped after word 3 -> after 63 idle cycles WORKING falls, COUNT_SENT=3, ABRUPT_STOP=1.
REQ-034 COUNT=8, DEVERR at word 4 with SRC_VALID=1 -> word 4 not written, COUNT_SENT=3, DEVERR and ABRUPT_STOP=1.
REQ-035 Two toggles, second during move (COUNT=4 each) -> second move starts the cycle after first returns IDLE; both complete, COUNT_SENT=4.
REQ-036 RST asserted mid-move with DST_READY toggling randomly -> all outputs zero same cycle; fresh toggle afterwards runs normally.
